// File: rtl/temp_log_sequencer.sv
// Temperature logger sequencer: sample timer, SPI read into the history register,
// and framed history dumps (header, count, entries newest first, checksum) to the UART.
module temp_log_sequencer #(
   parameter int         SAMPLE_DIV = 50000000,
   parameter bit         AUTO_DUMP  = 1'b1,
   parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        dump_req,
   output logic        spi_start,
   input  logic        spi_done,
   input  logic [7:0]  spi_data,
   output logic [7:0]  sr_in,
   output logic        sr_load,
   input  logic [79:0] hist,
   output logic [7:0]  uart_tx_data,
   output logic        uart_tx_start,
   input  logic        uart_tx_busy,
   output logic [3:0]  valid_count,
   output logic        overrun,
   output logic        busy
);

   localparam int            CW    = $clog2(SAMPLE_DIV);
   localparam logic [CW-1:0] TMAX  = CW'(SAMPLE_DIV - 1);
   localparam logic [3:0]    DEPTH = 4'd10;

   typedef enum logic [2:0] {
      IDLE,
      SPI_REQ,
      SPI_WAIT,
      STORE,
      TX_LOAD,
      TX_WAIT
   } state_t;

   state_t state_reg, state_next;

   logic [CW-1:0] tmr_reg;
   logic          tick;
   logic          samp_pend_reg;
   logic          dump_pend_reg;
   logic          overrun_reg;
   logic [3:0]    vcount_reg;
   logic [3:0]    new_cnt_reg;
   logic [7:0]    sr_in_reg;

   logic [3:0]    idx_reg;
   logic [3:0]    n_reg;
   logic [7:0]    csum_reg;
   logic          first_reg;

   logic [7:0]    entry [10];
   logic [3:0]    data_sel;
   logic [7:0]    data_byte;
   logic [7:0]    frame_byte;
   logic          is_data;
   logic          is_last;
   logic          tx_done;
   logic          frame_start;
   logic          auto_set;
   logic          in_dump;

   // Unpack the history bus into entries, entry 0 being the newest sample.
   genvar gi;
   generate
      for (gi = 0; gi < 10; gi++) begin : g_entry
         assign entry[gi] = hist[8*gi +: 8];
      end
   endgenerate

   assign tick        = enable && (tmr_reg == TMAX);
   assign data_sel    = idx_reg - 4'd2;
   assign is_data     = (idx_reg >= 4'd2) && (idx_reg < (n_reg + 4'd2));
   assign is_last     = (idx_reg == (n_reg + 4'd2));
   assign tx_done     = (state_reg == TX_WAIT) && !first_reg && !uart_tx_busy;
   assign frame_start = (state_reg == IDLE) && !samp_pend_reg && dump_pend_reg;
   assign auto_set    = AUTO_DUMP && (state_reg == STORE) && (new_cnt_reg == 4'd9);
   assign in_dump     = (state_reg == TX_LOAD) || (state_reg == TX_WAIT);

   always_comb begin
      data_byte = '0;
      for (int k = 0; k < 10; k++) begin
         if (data_sel == 4'(k)) begin
            data_byte = entry[k];
         end
      end
   end

   always_comb begin
      frame_byte = '0;
      if (idx_reg == 4'd0) begin
         frame_byte = HDR_BYTE;
      end else if (idx_reg == 4'd1) begin
         frame_byte = {4'b0, n_reg};
      end else if (is_last) begin
         frame_byte = csum_reg;
      end else begin
         frame_byte = data_byte;
      end
   end

   // Sample timer and request flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmr_reg       <= '0;
         samp_pend_reg <= 1'b0;
         dump_pend_reg <= 1'b0;
         overrun_reg   <= 1'b0;
      end else begin
         if (enable) begin
            tmr_reg <= tick ? '0 : tmr_reg + 1'b1;
         end
         // A tick landing in SPI_REQ refills the flag being consumed, so it is not an overrun.
         if (tick) begin
            samp_pend_reg <= 1'b1;
            if (samp_pend_reg && (state_reg != SPI_REQ)) begin
               overrun_reg <= 1'b1;
            end
         end else if (state_reg == SPI_REQ) begin
            samp_pend_reg <= 1'b0;
         end
         if (tx_done && is_last) begin
            dump_pend_reg <= 1'b0;
         end else if ((dump_req && !in_dump) || auto_set) begin
            dump_pend_reg <= 1'b1;
         end
      end
   end

   // Sample capture and bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_in_reg   <= '0;
         vcount_reg  <= '0;
         new_cnt_reg <= '0;
      end else begin
         if ((state_reg == SPI_WAIT) && spi_done) begin
            sr_in_reg <= spi_data;
         end
         if (state_reg == STORE) begin
            if (vcount_reg != DEPTH) begin
               vcount_reg <= vcount_reg + 4'd1;
            end
            if (auto_set) begin
               new_cnt_reg <= '0;
            end else if (new_cnt_reg != DEPTH) begin
               new_cnt_reg <= new_cnt_reg + 4'd1;
            end
         end
      end
   end

   // Frame sequencing: N is frozen at frame start, checksum accumulates as data bytes go out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_reg   <= '0;
         n_reg     <= '0;
         csum_reg  <= '0;
         first_reg <= 1'b0;
      end else begin
         if (frame_start) begin
            idx_reg  <= '0;
            n_reg    <= vcount_reg;
            csum_reg <= {4'b0, vcount_reg};
         end
         if (state_reg == TX_LOAD) begin
            first_reg <= 1'b1;
            if (is_data) begin
               csum_reg <= csum_reg + frame_byte;
            end
         end else if (state_reg == TX_WAIT) begin
            first_reg <= 1'b0;
            if (tx_done) begin
               idx_reg <= idx_reg + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      spi_start     = 1'b0;
      sr_load       = 1'b0;
      uart_tx_start = 1'b0;
      uart_tx_data  = '0;
      busy          = 1'b1;
      case (state_reg)
         IDLE: begin
            busy = 1'b0;
            if (samp_pend_reg) begin
               state_next = SPI_REQ;
            end else if (dump_pend_reg) begin
               state_next = TX_LOAD;
            end
         end
         SPI_REQ: begin
            spi_start  = 1'b1;
            state_next = SPI_WAIT;
         end
         SPI_WAIT: begin
            if (spi_done) begin
               state_next = STORE;
            end
         end
         STORE: begin
            sr_load    = 1'b1;
            state_next = IDLE;
         end
         TX_LOAD: begin
            uart_tx_start = 1'b1;
            uart_tx_data  = frame_byte;
            state_next    = TX_WAIT;
         end
         TX_WAIT: begin
            uart_tx_data = frame_byte;
            if (tx_done) begin
               state_next = is_last ? IDLE : TX_LOAD;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign sr_in       = sr_in_reg;
   assign valid_count = vcount_reg;
   assign overrun     = overrun_reg;

endmodule

// File: tb/tb_temp_log_sequencer.sv
// Directed bench for temp_log_sequencer with SPI, history-register and UART models.
module tb_temp_log_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        dump_req = 1'b0;
   logic        spi_start;
   logic        spi_done;
   logic [7:0]  spi_data;
   logic [7:0]  sr_in;
   logic        sr_load;
   logic [79:0] hist;
   logic [7:0]  uart_tx_data;
   logic        uart_tx_start;
   logic        uart_tx_busy = 1'b0;
   logic [3:0]  valid_count;
   logic        overrun;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] spi_seed = 8'h00;
   int         sdly;
   int         spi_cnt;
   int         uhold = 2;
   int         ucnt = 0;
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   int         loads = 0;
   int         loads_during_tx = 0;
   int         start_while_busy = 0;

   always #5 clk = ~clk;

   temp_log_sequencer #(
      .SAMPLE_DIV(16),
      .AUTO_DUMP(1'b1),
      .HDR_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .dump_req(dump_req),
      .spi_start(spi_start),
      .spi_done(spi_done),
      .spi_data(spi_data),
      .sr_in(sr_in),
      .sr_load(sr_load),
      .hist(hist),
      .uart_tx_data(uart_tx_data),
      .uart_tx_start(uart_tx_start),
      .uart_tx_busy(uart_tx_busy),
      .valid_count(valid_count),
      .overrun(overrun),
      .busy(busy)
   );

   // History register: entry 0 in the low byte, shifts toward older on each load.
   always @(posedge clk or posedge rst) begin
      if (rst) hist <= '0;
      else if (sr_load) hist <= {hist[71:0], sr_in};
   end

   // SPI slave: done follows start after a short fixed delay, data = seed + read number.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sdly     <= 0;
         spi_done <= 1'b0;
         spi_cnt  <= 0;
         spi_data <= '0;
      end else begin
         spi_done <= 1'b0;
         if (spi_start) begin
            sdly <= 3;
         end else if (sdly != 0) begin
            sdly <= sdly - 1;
            if (sdly == 1) begin
               spi_done <= 1'b1;
               spi_data <= spi_seed + 8'(spi_cnt);
               spi_cnt  <= spi_cnt + 1;
            end
         end
      end
   end

   // UART: busy for uhold cycles starting the cycle after start; logs each byte.
   always @(posedge clk) begin
      if (sr_load) begin
         loads <= loads + 1;
         if (uart_tx_busy) loads_during_tx <= loads_during_tx + 1;
      end
      if (uart_tx_start) begin
         if (uart_tx_busy) start_while_busy <= start_while_busy + 1;
         tx_q.push_back(uart_tx_data);
         $display("tx byte %0d = 0x%02h", tx_q.size() - 1, uart_tx_data);
         uart_tx_busy <= 1'b1;
         ucnt         <= uhold;
      end else if (ucnt > 1) begin
         ucnt <= ucnt - 1;
      end else begin
         ucnt         <= 0;
         uart_tx_busy <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk(tag, {spi_start, sr_load, uart_tx_start, overrun, busy,
                valid_count, uart_tx_data, sr_in}, 32'h0);
   endtask

   task automatic wait_tx(input int n, input int budget);
      int k = 0;
      while (tx_q.size() < n && k < budget) begin
         step(1);
         k++;
      end
      chk("wait_tx", 32'(tx_q.size() >= n), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy && k < budget) begin
         step(1);
         k++;
      end
      chk("wait_idle", 32'(busy), 32'd0);
   endtask

   task automatic wait_loads(input int n, input int budget);
      int k = 0;
      while (loads < n && k < budget) begin
         step(1);
         k++;
      end
      chk("wait_loads", 32'(loads >= n), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int base);
      logic [31:0] obs;
      for (int i = 0; i < exp_q.size(); i++) begin
         obs = (base + i < tx_q.size()) ? 32'(tx_q[base + i]) : 32'hFFFF_FFFF;
         chk($sformatf("%s[%0d]", tag, i), obs, 32'(exp_q[i]));
      end
   endtask

   initial begin
      int cyc;
      int base;
      int l0;
      int lt0;
      int sw0;

      // Reset state
      step(3);
      chk_outputs_zero("reset_outputs");

      // First sample: tick on the 16th enabled cycle, spi_start the cycle after
      spi_seed = 8'h19;
      rst      = 1'b0;
      enable   = 1'b1;
      cyc      = 0;
      while (!spi_start && cyc < 100) begin
         step(1);
         cyc++;
      end
      chk("t1_spi_start_cycle", cyc, 17);
      step(1);
      chk("t1_spi_start_width", 32'(spi_start), 0);
      cyc = 0;
      while (!sr_load && cyc < 50) begin
         step(1);
         cyc++;
      end
      chk("t1_sr_load", 32'(sr_load), 1);
      chk("t1_sr_in", 32'(sr_in), 32'h19);
      step(1);
      chk("t1_valid_count", 32'(valid_count), 1);
      chk("t1_busy_low", 32'(busy), 0);
      chk("t1_sr_in_held", 32'(sr_in), 32'h19);

      // Twelve samples 0x10..0x1B with an automatic dump after the tenth
      rst    = 1'b1;
      enable = 1'b0;
      step(2);
      spi_seed = 8'h10;
      uhold    = 2;
      base     = tx_q.size();
      l0       = loads;
      rst      = 1'b0;
      enable   = 1'b1;
      wait_tx(base + 13, 3000);
      exp_q = '{8'hA5, 8'h0A, 8'h19, 8'h18, 8'h17, 8'h16, 8'h15,
                8'h14, 8'h13, 8'h12, 8'h11, 8'h10, 8'hD7};
      check_frame("t2_frame", base);
      wait_loads(l0 + 12, 1000);
      enable = 1'b0;
      chk("t2_valid_count_sat", 32'(valid_count), 10);
      wait_idle(100);
      step(30);
      chk("t2_frame_len", tx_q.size() - base, 13);

      // Empty frame right after reset, with UART slow enough to overrun the timer
      rst    = 1'b1;
      step(2);
      spi_seed = 8'h55;
      uhold    = 40;
      base     = tx_q.size();
      l0       = loads;
      lt0      = loads_during_tx;
      sw0      = start_while_busy;
      rst      = 1'b0;
      enable   = 1'b1;
      dump_req = 1'b1;
      step(1);
      dump_req = 1'b0;
      wait_tx(base + 2, 200);
      enable = 1'b0;
      wait_tx(base + 3, 200);
      wait_loads(l0 + 1, 200);
      step(60);
      exp_q = '{8'hA5, 8'h00, 8'h00};
      check_frame("t3_frame", base);
      chk("t3_frame_len", tx_q.size() - base, 3);
      chk("t3_start_while_busy", start_while_busy - sw0, 0);
      chk("t4_overrun", 32'(overrun), 1);
      chk("t4_load_in_frame", loads_during_tx - lt0, 0);
      chk("t4_loads_after", loads - l0, 1);
      chk("t4_valid_count", 32'(valid_count), 1);
      chk("t4_sr_in", 32'(sr_in), 32'h55);
      chk("t4_busy_low", 32'(busy), 0);

      // Asynchronous reset in TX_WAIT mid-frame
      base     = tx_q.size();
      dump_req = 1'b1;
      step(1);
      dump_req = 1'b0;
      wait_tx(base + 2, 200);
      step(5);
      chk("t5_busy_before", 32'(busy), 1);
      chk("t5_count_byte", 32'(uart_tx_data), 1);
      #2 rst = 1'b1;
      #1 chk_outputs_zero("t5_async_reset");
      step(1);
      rst = 1'b0;
      step(60);
      chk("t5_no_more_tx", tx_q.size() - base, 2);
      chk("t5_idle", 32'(busy), 0);
      base     = tx_q.size();
      dump_req = 1'b1;
      step(1);
      dump_req = 1'b0;
      wait_tx(base + 3, 400);
      wait_idle(100);
      exp_q = '{8'hA5, 8'h00, 8'h00};
      check_frame("t5_fresh_frame", base);

      // Tick and dump_req in the same IDLE cycle: sample first, then frame
      rst = 1'b1;
      step(2);
      spi_seed = 8'h3C;
      uhold    = 2;
      base     = tx_q.size();
      rst      = 1'b0;
      enable   = 1'b1;
      repeat (15) @(posedge clk);
      #1 dump_req = 1'b1;
      @(posedge clk);
      #1 dump_req = 1'b0;
      enable = 1'b0;
      wait_tx(base + 4, 200);
      wait_idle(100);
      step(10);
      exp_q = '{8'hA5, 8'h01, 8'h3C, 8'h3D};
      check_frame("t6_frame", base);
      chk("t6_frame_len", tx_q.size() - base, 4);
      chk("t6_valid_count", 32'(valid_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
